// File: rtl/aes_pkg.sv
// aes_pkg: shared AES interface encodings, block geometry and output-interface FSM states
package aes_pkg;
    localparam logic [1:0] C_ID = 2'b00;
    localparam logic [1:0] C_SP = 2'b01;
    localparam logic [1:0] C_SK = 2'b10;
    localparam logic [1:0] C_ST = 2'b11;
    localparam int AES_BLOCK_BYTES = 16;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01,
        S_ACK  = 2'b10
    } state_t;
endpackage

// File: rtl/aes_byte_serializer.sv
// aes_byte_serializer: load/shift register with byte counter, MSB byte first
module aes_byte_serializer #(
    parameter int DATA_W = 128,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_last
);
    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES);

    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            r_cnt   <= r_cnt + 1'b1;
        end else if (i_clear) begin
            r_shreg <= '0;
        end
    end

    assign o_byte = r_shreg[DATA_W-1 -: BYTE_W];
    assign o_last = (r_cnt == CNT_W'(NBYTES-1));
endmodule

// File: rtl/aes_output_interface.sv
// aes_output_interface: captures ciphertext on engine-done edge and streams it as bytes over valid/ready.
// Build option AES_OUT_ZEROIZE_EN scrubs the register after the read and masks dout while idle.
module aes_output_interface #(
    parameter int DATA_W = 128,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] ct_in,
    input  logic              ct_valid,
    input  logic              dout_ready,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    output logic              busy,
    output logic              output_read
);
    import aes_pkg::*;

    state_t            r_state;
    logic              r_ct_valid_q;
    logic              w_capture;
    logic              w_fire;
    logic              w_done;
    logic              w_clear;
    logic [BYTE_W-1:0] w_byte;

    // Only a rising edge of the done level starts a transfer, so a held level never re-triggers
    assign w_capture = (r_state == S_IDLE) & ct_valid & ~r_ct_valid_q;
    assign w_fire    = (r_state == S_SEND) & dout_ready;
    assign w_done    = w_fire & dout_last;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state      <= S_IDLE;
            r_ct_valid_q <= 1'b0;
        end else begin
            r_ct_valid_q <= ct_valid;
            r_state      <= w_capture ? S_SEND :
                            w_done ? S_ACK :
                            (r_state == S_ACK) ? S_IDLE : r_state;
        end
    end

    assign dout_valid  = (r_state == S_SEND);
    assign busy        = (r_state != S_IDLE);
    assign output_read = (r_state == S_ACK);

`ifdef AES_OUT_ZEROIZE_EN
    assign w_clear = w_done;
    assign dout    = dout_valid ? w_byte : '0;
`else
    assign w_clear = 1'b0;
    assign dout    = w_byte;
`endif

    aes_byte_serializer #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) u_ser (
        .clk     (clk),
        .rst_    (rst_),
        .i_load  (w_capture),
        .i_shift (w_fire & ~dout_last),
        .i_clear (w_clear),
        .i_data  (ct_in),
        .o_byte  (w_byte),
        .o_last  (dout_last)
    );
endmodule

// File: tb/tb_aes_output_interface.sv
// tb_aes_output_interface: randomized and directed checks of the byte-serial ciphertext output port
module tb_aes_output_interface;
    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic [127:0] ct_in = '0;
    logic         ct_valid = 1'b0;
    logic         dout_ready = 1'b0;
    logic [7:0]   dout;
    logic         dout_valid, dout_last, busy, output_read;

    int checks = 0;
    int failures = 0;
    localparam logic [127:0] KAT = 128'h3925841D02DC09FBDC118597196A0B32;

    always #5 clk = ~clk;

    aes_output_interface dut (
        .clk         (clk),
        .rst_        (rst_),
        .ct_in       (ct_in),
        .ct_valid    (ct_valid),
        .dout_ready  (dout_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_last   (dout_last),
        .busy        (busy),
        .output_read (output_read)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: byte i of a block is bits [127-8i -: 8]; ready policy per mode
    function automatic logic [7:0] ref_byte(input logic [127:0] ct, input int i);
        return ct[127-8*i -: 8];
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'(($urandom & 1) == 1);
    endfunction

    // Runs one block; abort_at >= 0 resets the DUT once that many beats have been accepted
    task automatic xfer(input logic [127:0] ct, input int mode, input int hold, input int abort_at);
        int idx = 0;
        int cyc = 0;
        @(negedge clk);
        ct_valid = 1'b0;
        dout_ready = 1'b0;
        @(negedge clk);
        ct_in = ct;
        ct_valid = 1'b1;
        @(negedge clk);
        if (hold == 0) ct_valid = 1'b0;
        while (idx < 16 && cyc < 400) begin
            if (idx == abort_at) begin
                #1 rst_ = 1'b0;
                #1;
                check("abort_valid", 128'(dout_valid), 128'(0));
                check("abort_busy", 128'(busy), 128'(0));
                check("abort_dout", 128'(dout), 128'(0));
                @(negedge clk);
                rst_ = 1'b1;
                ct_valid = 1'b0;
                dout_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("abort_no_read", 128'(output_read), 128'(0));
                end
                return;
            end
            check("send_valid", 128'(dout_valid), 128'(1));
            check("send_busy", 128'(busy), 128'(1));
            check("send_byte", 128'(dout), 128'(ref_byte(ct, idx)));
            check("send_last", 128'(dout_last), 128'(idx == 15));
            check("send_no_read", 128'(output_read), 128'(0));
            dout_ready = ready_for(mode, cyc);
            @(negedge clk);
            if (dout_ready) idx++;
            cyc++;
        end
        check("beats_done", 128'(idx), 128'(16));
        if (mode == 0) check("throughput", 128'(cyc), 128'(16));
        check("ack_read", 128'(output_read), 128'(1));
        check("ack_valid", 128'(dout_valid), 128'(0));
        check("ack_busy", 128'(busy), 128'(1));
        dout_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_read", 128'(output_read), 128'(0));
            check("post_valid", 128'(dout_valid), 128'(0));
            check("post_busy", 128'(busy), 128'(0));
        end
`ifdef AES_OUT_ZEROIZE_EN
        check("idle_dout", 128'(dout), 128'(0));
`else
        check("idle_dout", 128'(dout), 128'(ref_byte(ct, 15)));
`endif
        ct_valid = 1'b0;
    endtask

    initial begin
        ct_in = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(negedge clk);
        check("rst_valid", 128'(dout_valid), 128'(0));
        check("rst_read", 128'(output_read), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_dout", 128'(dout), 128'(0));
        rst_ = 1'b1;
        dout_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready_noop", 128'(dout_valid), 128'(0));
        end
        xfer(KAT, 0, 0, -1);
        xfer(KAT, 1, 0, -1);
        xfer(KAT, 0, 1, -1);
        xfer(KAT, 0, 0, 6);
        xfer(KAT, 0, 0, -1);
        for (int t = 0; t < 6; t++)
            xfer({$urandom, $urandom, $urandom, $urandom}, 2, t % 2, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
